// File: rtl/hadamard16_seq_ctrl.sv
// ---------------------------------------------------------------------------
// hadamard16_seq_ctrl
//
// Sequential 16-point Sylvester-ordered Walsh-Hadamard transform. Sixteen
// signed 9-bit samples are loaded into a 13-bit register file. One shared
// butterfly (a+b, a-b) is then applied per cycle, in place, over 4 stages
// of 8 butterflies each. The sixteen results are drained in natural order
// under a valid/ready handshake.
//
// Optional build macro:
//   HADAMARD_OUT_SAT9_EN - each result is saturated to [-256, 255] and
//                          sign-extended to 13 bits on out_data.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a frame (sampled only in IDLE)
//   in_valid   in_data carries a sample
//   in_data    signed 9-bit sample, x0 first
//   in_ready   block accepts a sample this cycle (LOAD only)
//   out_valid  out_data carries a result (DRAIN only)
//   out_data   signed 13-bit result, y0 first
//   out_ready  downstream accepts out_data
//   out_last   marks y15
//   busy       high in every state except IDLE
//   done       one-cycle pulse in the first IDLE cycle after DRAIN
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// LOAD    | accepting x0..x15 into the register file
// COMPUTE | 32 in-place butterflies, stride 8, 4, 2, 1
// DRAIN   | presenting y0..y15 on out_data
// ---------------------------------------------------------------------------
module hadamard16_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [8:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [12:0] out_data,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  load_cnt_q, load_cnt_d;
  logic [4:0]  comp_cnt_q, comp_cnt_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic        done_q, done_d;
  logic [12:0] rf_q [16];
  logic [12:0] rf_d [16];

  logic        in_acc;
  logic        out_acc;
  logic [1:0]  bf_stage;
  logic [2:0]  bf_num;
  logic [3:0]  bf_idx_a;
  logic [3:0]  bf_idx_b;
  logic [12:0] bf_sum;
  logic [12:0] bf_diff;
  logic [12:0] out_res;
  logic [12:0] out_fmt;

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

  // Butterfly pair for this cycle: the stage picks the stride bit (8,4,2,1),
  // the butterfly number fills the remaining three index bits around it.
  assign bf_stage = comp_cnt_q[4:3];
  assign bf_num   = comp_cnt_q[2:0];

  always_comb begin
    bf_idx_a = 4'd0;
    bf_idx_b = 4'd0;
    case (bf_stage)
      2'd0: begin
        bf_idx_a = {1'b0, bf_num};
        bf_idx_b = {1'b1, bf_num};
      end
      2'd1: begin
        bf_idx_a = {bf_num[2], 1'b0, bf_num[1:0]};
        bf_idx_b = {bf_num[2], 1'b1, bf_num[1:0]};
      end
      2'd2: begin
        bf_idx_a = {bf_num[2:1], 1'b0, bf_num[0]};
        bf_idx_b = {bf_num[2:1], 1'b1, bf_num[0]};
      end
      default: begin
        bf_idx_a = {bf_num, 1'b0};
        bf_idx_b = {bf_num, 1'b1};
      end
    endcase
  end

  // 16 * 256 = 4096 fits 13-bit two's complement, so no wrap is possible.
  assign bf_sum  = rf_q[bf_idx_a] + rf_q[bf_idx_b];
  assign bf_diff = rf_q[bf_idx_a] - rf_q[bf_idx_b];

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    comp_cnt_d  = comp_cnt_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          load_cnt_d = 4'd0;
        end
      end
      ST_LOAD: begin
        if (in_acc) begin
          load_cnt_d = load_cnt_q + 4'd1;
          if (load_cnt_q == 4'd15) begin
            state_d    = ST_COMPUTE;
            comp_cnt_d = 5'd0;
          end
        end
      end
      ST_COMPUTE: begin
        comp_cnt_d = comp_cnt_q + 5'd1;
        if (comp_cnt_q == 5'd31) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 4'd0;
        end
      end
      default: begin
        if (out_acc) begin
          drain_cnt_d = drain_cnt_q + 4'd1;
          if (drain_cnt_q == 4'd15) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < 16; i++) rf_d[i] = rf_q[i];
    if (in_acc) begin
      rf_d[load_cnt_q] = {{4{in_data[8]}}, in_data};
    end else if (state_q == ST_COMPUTE) begin
      rf_d[bf_idx_a] = bf_sum;
      rf_d[bf_idx_b] = bf_diff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_cnt_q  <= 4'd0;
      comp_cnt_q  <= 5'd0;
      drain_cnt_q <= 4'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      comp_cnt_q  <= comp_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
    end
  end

  // Register file is data-only; a reset discards the frame by state alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) rf_q[i] <= rf_d[i];
  end

  assign out_res = rf_q[drain_cnt_q];

`ifdef HADAMARD_OUT_SAT9_EN
  always_comb begin
    out_fmt = out_res;
    if (out_res[12] && (out_res[11:8] != 4'hF)) begin
      out_fmt = 13'h1F00;
    end else if (!out_res[12] && (out_res[11:8] != 4'h0)) begin
      out_fmt = 13'h00FF;
    end
  end
`else
  assign out_fmt = out_res;
`endif

  // Outputs are a function of state and drain counter only, so they hold
  // naturally while out_ready is low.
  assign out_data = out_valid ? out_fmt : 13'd0;
  assign out_last = out_valid && (drain_cnt_q == 4'd15);

endmodule

// File: tb/tb_hadamard16_seq_ctrl.sv
module tb_hadamard16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [8:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [12:0] out_data;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  hadamard16_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   xs[16];
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   done_cnt = 0;
  bit   seen_valid = 0;
  bit   prev_stall = 0;
  int   prev_data = 0;
  int   prev_last = 0;
  bit   bp_mode = 0;
  int   bp_idx = 0;
  logic [3:0] bp_pat = 4'b1001;

  task automatic check(string tag, int obs, int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_y(int k);
    int s = 0;
    for (int n = 0; n < 16; n++) begin
      if ($countones(k & n) % 2 == 1) s -= xs[n];
      else s += xs[n];
    end
`ifdef HADAMARD_OUT_SAT9_EN
    if (s > 255) s = 255;
    if (s < -256) s = -256;
`endif
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      out_ready = bp_pat[bp_idx % 4];
      bp_idx++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Output monitor: scoreboard pop, stall stability, first-output latency.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      seen_valid = 0;
    end else begin
      if (out_valid && !seen_valid) begin
        seen_valid = 1;
        check("latency", cyc - last_acc_cyc, 33);
      end
      if (prev_stall) begin
        check("stall_data", int'($signed(out_data)), prev_data);
        check("stall_last", int'(out_last), prev_last);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 0, 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("y_data", int'($signed(out_data)), e.val);
          check("y_last", int'(out_last), e.last);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = int'($signed(out_data));
      prev_last  = int'(out_last);
      if (done) done_cnt++;
    end
  end

  task automatic load_frame(bit gap, bit hold);
    int i = 0;
    int n = 0;
    for (int k = 0; k < 16; k++) sb.push_back('{exp_y(k), (k == 15) ? 1 : 0});
    @(posedge clk); #1;
    seen_valid = 0;
    start = 1'b1;
    while (i < 16 && n < 200) begin
      in_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = xs[i][8:0];
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (i == 15) last_acc_cyc = cyc;
        i++;
      end
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    if (i < 16) check("load_timeout", i, 16);
  endtask

  task automatic wait_done(bit hold, int done_before);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 400);
    if (!done) begin
      check("done_timeout", 0, 1);
    end else begin
      check("busy_at_done", int'(busy), 0);
      @(negedge clk);
      check("done_width", int'(done), 0);
      check("done_count", done_cnt, done_before + 1);
      check("in_ready_after_done", int'(in_ready), hold ? 1 : 0);
    end
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last",  int'(out_last), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_done",      int'(done), 0);
    check("rst_out_data",  int'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Impulse
    for (int i = 0; i < 16; i++) xs[i] = (i == 0) ? 1 : 0;
    d0 = done_cnt;
    load_frame(0, 0);
    wait_done(0, d0);

    // Mixed vector
    xs = '{2, -1, 2, -3, 1, -2, 3, 0, 5, 1, -2, -1, 2, 4, 6, -1};
    d0 = done_cnt;
    load_frame(0, 0);
    wait_done(0, d0);

    // Full scale positive and negative
    for (int i = 0; i < 16; i++) xs[i] = 255;
    d0 = done_cnt;
    load_frame(0, 0);
    wait_done(0, d0);
    for (int i = 0; i < 16; i++) xs[i] = -256;
    d0 = done_cnt;
    load_frame(0, 0);
    wait_done(0, d0);

    // Backpressure with gapped input
    for (int i = 0; i < 16; i++) xs[i] = $urandom_range(0, 511) - 256;
    bp_mode = 1;
    d0 = done_cnt;
    load_frame(1, 0);
    wait_done(0, d0);
    bp_mode = 0;

    // Reset at compute cycle 10
    for (int i = 0; i < 16; i++) xs[i] = 7 * i - 50;
    d0 = done_cnt;
    load_frame(0, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy",      int'(busy), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready",  int'(in_ready), 0);
    check("abort_done",      int'(done), 0);
    sb.delete();
    for (int i = 0; i < 16; i++) xs[i] = 3 - i;
    load_frame(0, 0);
    wait_done(0, d0);

    // start held high through a whole frame, then a back-to-back frame
    for (int i = 0; i < 16; i++) xs[i] = (i % 3 == 0) ? 100 : -37;
    d0 = done_cnt;
    load_frame(0, 1);
    wait_done(1, d0);
    start = 1'b0;
    for (int i = 0; i < 16; i++) xs[i] = i * i - 100;
    d0 = done_cnt;
    load_frame(0, 0);
    wait_done(0, d0);

    check("sb_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hadamard16_seq_ctrl.md
HADAMARD16_SEQ_CTRL -- requirements
Module: hadamard16_seq_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  one clock; reset is synchronous and active-high.
REQ-003 start  input  1  begin a new 16-point frame; sampled only in IDLE.
REQ-004 in_valid  input  1  in_data carries a sample.
REQ-005 in_data  input  9  signed input sample, x0 first, x15 last.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 out_valid  output  1  out_data carries a result.
REQ-008 out_data  output  13  signed result, y0 first, y15 last.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_last  output  1  high with out_valid on y15 only.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on the cycle after y15 is accepted.

Function
REQ-013 The block SHALL compute the 16-point Sylvester-ordered Walsh-Hadamard transform, y_k = sum over n of (-1)^popcount(k AND n) * x_n, with no scaling.
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, COMPUTE and DRAIN.
- IDLE -> LOAD when start=1.
- LOAD -> COMPUTE after the 16th accepted sample.
- COMPUTE -> DRAIN after 32 cycles.
- DRAIN -> IDLE after y15 is accepted.
REQ-015 in_ready SHALL be 1 only in LOAD, and a sample SHALL be accepted only when in_valid=1 and in_ready=1; in_valid in other states SHALL be ignored.
REQ-016 Loaded samples SHALL be sign-extended to 13 bits into a 16-entry register file indexed by a 4-bit load counter.
REQ-017 COMPUTE SHALL use a single shared butterfly (a+b, a-b), executing one butterfly per cycle in place.
- Order: stage 0..3 with stride 8, 4, 2, 1.
- 8 butterflies per stage, 32 cycles total.
- Outputs are produced in natural order with no reordering.
REQ-018 All internal arithmetic SHALL be 13-bit two's complement; no overflow can occur for 9-bit inputs.
REQ-019 In DRAIN, out_valid SHALL be 1 and out_data SHALL present entry j of the 4-bit drain counter; j advances only when out_valid=1 and out_ready=1.
REQ-020 While out_ready=0, out_data and out_last SHALL hold their values.
REQ-021 The latency from the cycle the 16th sample is accepted to the first out_valid=1 SHALL be exactly 33 cycles.
REQ-022 done SHALL pulse for one cycle in the first IDLE cycle after DRAIN; start in that same cycle SHALL be honoured.
REQ-023 start asserted outside IDLE SHALL be ignored.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL:
- enter IDLE;
- clear all counters;
- drive in_ready=0, out_valid=0, out_last=0, busy=0, done=0 and out_data=0.
REQ-025 Reset asserted mid-LOAD, mid-COMPUTE or mid-DRAIN SHALL discard the frame; the register file contents need not be cleared.

Configuration
REQ-026 With macro HADAMARD_OUT_SAT9_EN defined, out_data SHALL be each result saturated to the range [-256, 255] and sign-extended to 13 bits. Without the macro, out_data SHALL carry the full 13-bit result. Port widths SHALL be identical in both builds.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Impulse: x0=1, others 0 -> all sixteen y = 1; out_last high on y15 only; done pulses once.
- Vector: x=2,-1,2,-3,1,-2,3,0,5,1,-2,-1,2,4,6,-1 -> y0=16, y1=22; first out_valid exactly 33 cycles after the 16th accept.
- Full scale: all x=255 -> y0=4080 (255 with HADAMARD_OUT_SAT9_EN), y1..y15=0; all x=-256 -> y0=-4096 (-256 saturated).
- Backpressure: out_ready toggled 1,0,0,1 repeatedly, and in_valid gapped in LOAD -> no lost, duplicated or reordered samples; out_data stable while stalled.
- Reset mid-COMPUTE at cycle 10 -> next cycle IDLE with busy=0 and out_valid=0; the following frame produces correct results.
- start held high through a frame -> ignored while busy; a new LOAD begins on the done cycle.
